// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, verdict encoding
// and the single-bit GT/EQ/LT compare.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    typedef logic [1:0] verdict_t;

    localparam verdict_t CMP_EQ = 2'b00;
    localparam verdict_t CMP_GT = 2'b01;
    localparam verdict_t CMP_LT = 2'b10;

    function automatic verdict_t bit_cmp(input logic a, input logic b);
        verdict_t v;
        if (a && !b) begin
            v = CMP_GT;
        end else if (!a && b) begin
            v = CMP_LT;
        end else begin
            v = CMP_EQ;
        end
        return v;
    endfunction

endpackage

// File: rtl/serial_cmp_fold.sv
// Combinational next-verdict fold. Bit order selected by SERIAL_MAG_COMPARATOR_LSB_FIRST_EN
// (undefined: MSB-first, first differing bit decides).
module serial_cmp_fold
    import serial_cmp_pkg::*;
(
    input  verdict_t verdict_i,
    input  logic     a_bit_i,
    input  logic     b_bit_i,
    output verdict_t verdict_o
);

    verdict_t bit_verdict;

    assign bit_verdict = bit_cmp(a_bit_i, b_bit_i);

`ifdef SERIAL_MAG_COMPARATOR_LSB_FIRST_EN
    // Later bits are more significant, so any difference overwrites.
    assign verdict_o = (bit_verdict != CMP_EQ) ? bit_verdict : verdict_i;
`else
    assign verdict_o = (verdict_i == CMP_EQ) ? bit_verdict : verdict_i;
`endif

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial WIDTH-bit magnitude comparator: FSM, bit counter and registered GT/EQ/LT.
// Bit order follows SERIAL_MAG_COMPARATOR_LSB_FIRST_EN (see serial_cmp_fold).
module serial_mag_comparator
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic bit_valid_i,
    input  logic a_bit_i,
    input  logic b_bit_i,
    output logic busy_o,
    output logic done_o,
    output logic gt_o,
    output logic eq_o,
    output logic lt_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    verdict_t        verdict_q;
    verdict_t        verdict_d;
    logic            busy_q;
    logic            done_q;
    logic            gt_q;
    logic            eq_q;
    logic            lt_q;

    serial_cmp_fold u_fold (
        .verdict_i (verdict_q),
        .a_bit_i   (a_bit_i),
        .b_bit_i   (b_bit_i),
        .verdict_o (verdict_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            verdict_q <= CMP_EQ;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_q   <= StShift;
                        cnt_q     <= '0;
                        verdict_q <= CMP_EQ;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StShift: begin
                    if (bit_valid_i) begin
                        cnt_q     <= cnt_q + CntOne;
                        verdict_q <= verdict_d;
                        if (cnt_q == LastIdx) begin
                            // Final verdict includes the bit accepted on this edge.
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            gt_q    <= (verdict_d == CMP_GT);
                            eq_q    <= (verdict_d == CMP_EQ);
                            lt_q    <= (verdict_d == CMP_LT);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign gt_o   = gt_q;
    assign eq_o   = eq_q;
    assign lt_o   = lt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed, table-driven bench for serial_mag_comparator (WIDTH=8 and WIDTH=1 instances).
module tb_serial_mag_comparator;

    logic clk;
    logic rst_n;
    logic start, bit_valid, a_bit, b_bit;
    logic busy, done, gt, eq, lt;
    logic start1, valid1, a1, b1;
    logic busy1, done1, gt1, eq1, lt1;

    int n_checks;
    int n_fail;

    serial_mag_comparator #(.WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .bit_valid_i (bit_valid),
        .a_bit_i     (a_bit),
        .b_bit_i     (b_bit),
        .busy_o      (busy),
        .done_o      (done),
        .gt_o        (gt),
        .eq_o        (eq),
        .lt_o        (lt)
    );

    serial_mag_comparator #(.WIDTH(1)) dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start1),
        .bit_valid_i (valid1),
        .a_bit_i     (a1),
        .b_bit_i     (b1),
        .busy_o      (busy1),
        .done_o      (done1),
        .gt_o        (gt1),
        .eq_o        (eq1),
        .lt_o        (lt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] stall;     // bit i set: bit_valid low on run cycle i
        logic        start_in_shift;
        int          gap;       // idle cycles before the run (0 = back-to-back from DONE)
        logic [2:0]  exp_res;   // {gt, eq, lt}
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bit_pos(input int idx);
`ifdef SERIAL_MAG_COMPARATOR_LSB_FIRST_EN
        return idx;
`else
        return 7 - idx;
`endif
    endfunction

    // Entered #1 after an edge; returns #1 after the edge that raised done (or on timeout).
    task automatic do_run(input logic [7:0] a, input logic [7:0] b, input logic [15:0] stall,
                          input logic start_in_shift, output int lat, output int busy_ok);
        int idx;
        int cyc;
        idx     = 0;
        cyc     = 0;
        lat     = -1;
        busy_ok = 1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy !== 1'b1) busy_ok = 0;
        while (cyc < 40 && lat < 0) begin
            start = start_in_shift && (idx < 8);
            if (idx >= 8 || (cyc < 16 && stall[cyc])) begin
                // Garbage on the data lines while not valid
                bit_valid = 1'b0;
                a_bit     = 1'b1;
                b_bit     = 1'b0;
            end else begin
                bit_valid = 1'b1;
                a_bit     = a[bit_pos(idx)];
                b_bit     = b[bit_pos(idx)];
            end
            @(posedge clk);
            #1;
            if (bit_valid) idx++;
            cyc++;
            if (done === 1'b1) begin
                lat = cyc;
                if (busy !== 1'b0) busy_ok = 0;
            end else if (busy !== 1'b1) begin
                busy_ok = 0;
            end
        end
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    initial begin
        int lat;
        int busy_ok;
        logic [2:0] prev_res;

        n_checks  = 0;
        n_fail    = 0;
        start     = 1'b0;
        bit_valid = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        start1    = 1'b0;
        valid1    = 1'b0;
        a1        = 1'b0;
        b1        = 1'b0;

        vecs[0] = '{a: 8'hA5, b: 8'hA4, stall: 16'h0000, start_in_shift: 1'b0, gap: 2,
                    exp_res: 3'b100, exp_lat: 8};
        vecs[1] = '{a: 8'h3C, b: 8'h3C, stall: 16'h0052, start_in_shift: 1'b0, gap: 3,
                    exp_res: 3'b010, exp_lat: 11};
        vecs[2] = '{a: 8'h01, b: 8'h80, stall: 16'h0000, start_in_shift: 1'b0, gap: 1,
                    exp_res: 3'b001, exp_lat: 8};
        vecs[3] = '{a: 8'h80, b: 8'h7F, stall: 16'h0000, start_in_shift: 1'b1, gap: 2,
                    exp_res: 3'b100, exp_lat: 8};
        vecs[4] = '{a: 8'h7F, b: 8'h80, stall: 16'h0000, start_in_shift: 1'b0, gap: 0,
                    exp_res: 3'b001, exp_lat: 8};
        vecs[5] = '{a: 8'h55, b: 8'h54, stall: 16'h0101, start_in_shift: 1'b1, gap: 0,
                    exp_res: 3'b100, exp_lat: 10};
        vecs[6] = '{a: 8'h00, b: 8'hFF, stall: 16'h0000, start_in_shift: 1'b0, gap: 4,
                    exp_res: 3'b001, exp_lat: 8};
        vecs[7] = '{a: 8'h12, b: 8'h12, stall: 16'h0000, start_in_shift: 1'b0, gap: 0,
                    exp_res: 3'b010, exp_lat: 8};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_w8_outputs", {busy, done, gt, eq, lt}, 5'b00000);
        check("reset_w1_outputs", {busy1, done1, gt1, eq1, lt1}, 5'b00000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        prev_res = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].gap > 0) begin
                for (int g = 0; g < vecs[i].gap; g++) begin
                    bit_valid = ~bit_valid;
                    a_bit     = 1'b1;
                    b_bit     = 1'b0;
                    @(posedge clk);
                    #1;
                end
                bit_valid = 1'b0;
                check($sformatf("idle_hold_v%0d", i), {busy, done, gt, eq, lt},
                      {2'b00, prev_res});
            end
            do_run(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].start_in_shift, lat, busy_ok);
            check($sformatf("latency_v%0d", i), lat, vecs[i].exp_lat);
            check($sformatf("result_v%0d", i), {gt, eq, lt}, vecs[i].exp_res);
            check($sformatf("busy_v%0d", i), busy_ok, 1);
            prev_res = vecs[i].exp_res;
        end

        // done is a single-cycle pulse; the verdict holds afterwards
        @(posedge clk);
        #1;
        check("done_pulse_w8", {busy, done, gt, eq, lt}, {2'b00, prev_res});

        // Reset after four accepted bits aborts the run at once
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bit_valid = 1'b1;
            a_bit     = 1'b1;
            b_bit     = 1'b0;
            @(posedge clk);
            #1;
        end
        bit_valid = 1'b0;
        check("mid_run_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_run_reset", {busy, done, gt, eq, lt}, 5'b00000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_run(8'hFF, 8'h00, 16'h0000, 1'b0, lat, busy_ok);
        check("post_reset_latency", lat, 8);
        check("post_reset_result", {gt, eq, lt}, 3'b100);

        // WIDTH=1: the first accepted bit completes the run
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("w1_busy", busy1, 1);
        valid1 = 1'b1;
        a1     = 1'b0;
        b1     = 1'b1;
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        check("w1_done", {busy1, done1}, 2'b01);
        check("w1_result", {gt1, eq1, lt1}, 3'b001);
        @(posedge clk);
        #1;
        check("w1_hold", {busy1, done1, gt1, eq1, lt1}, 5'b00001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_mag_comparator.md
# serial_mag_comparator

Bit-serial N-bit magnitude comparator built around the team's 1-bit GT/EQ/LT comparison. It consumes one bit pair of operands A and B per accepted cycle and folds each per-bit GT/EQ/LT into a running verdict. After WIDTH bits it presents a registered word-level GT/EQ/LT with a one-cycle done pulse. It sits downstream of a serialiser (shift register or serial link) and feeds control logic that needs word comparisons without a WIDTH-bit parallel comparator.

## Interface
- WIDTH, 8, operand width in bits; must be ≥1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin a new comparison; honoured in IDLE or DONE only.
- bit_valid  in  1  a_bit/b_bit carry a valid bit pair this cycle.
- a_bit  in  1  current bit of operand A.
- b_bit  in  1  current bit of operand B.
- busy  out  1  high while in SHIFT (bits being accepted).
- done  out  1  one-cycle pulse: result registers just updated.
- gt  out  1  A > B for the last completed comparison.
- eq  out  1  A == B for the last completed comparison.
- lt  out  1  A < B for the last completed comparison.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 → SHIFT, bit counter cleared to 0, running verdict set to EQ. bit_valid is ignored.
- SHIFT: each cycle with bit_valid=1 is one accepted bit; the counter increments. bit_valid=0 stalls with no state change. start is ignored.
- Per-bit compare: a&~b → GT, ~a&b → LT, otherwise EQ.
- Fold rule (MSB-first, default): if the running verdict is EQ, take the per-bit result; otherwise hold. The first differing bit decides.
- On accepting bit number WIDTH-1: go to DONE, load gt/eq/lt with the final verdict (including this bit), and assert done.
- DONE lasts one cycle. start=1 → SHIFT (back-to-back run); otherwise → IDLE.
- gt/eq/lt hold their value until the next completion. Exactly one is high after any completion.
- Counter width is $clog2(WIDTH+1). For WIDTH=1, the first accepted bit completes the run.

## Timing
- Reset (async, rst_n=0): state IDLE, counter 0, verdict EQ, busy=0, done=0, gt=0, eq=0, lt=0. The all-zero output means "no result yet".
- start sampled at edge T0 → busy=1 after T0. The first bit can be accepted at edge T0+1.
- Minimum latency from the start edge to done high: WIDTH cycles (no stalls). Each stall cycle adds one.
- done and the new gt/eq/lt become visible together after the edge that accepts the last bit.
- Reset mid-run aborts immediately. No done is produced and the outputs return to 000.
- All outputs are registered; none are combinational from inputs.

## Configuration
- SERIAL_MAG_COMPARATOR_LSB_FIRST_EN defined: bits arrive LSB-first. The fold rule becomes "a non-EQ per-bit result overwrites the verdict; an EQ per-bit result holds it", so the last differing bit (the most significant one) decides.
- Undefined: MSB-first fold rule as above.
- The interface, latency and FSM are identical in both modes.

## Structure
- Shared package serial_cmp_pkg:
  - state enum typedef (IDLE/SHIFT/DONE).
  - 2-bit verdict typedef with constants CMP_EQ, CMP_GT, CMP_LT.
  - per-bit compare function returning a verdict.
- One sub-module: serial_cmp_fold, a purely combinational next-verdict from (current verdict, a_bit, b_bit). It contains the only macro-dependent logic.
- The top level holds the FSM, counter and output registers.

## Test plan
- WIDTH=8, MSB-first, A=0xA5, B=0xA4, no stalls → done 8 cycles after the start edge; gt=1, eq=0, lt=0.
- A=B=0x3C, with bit_valid low for 3 random cycles → done at 11 cycles; eq=1. busy is high throughout SHIFT.
- A=0x01, B=0x80, run twice: once MSB-first, once with the LSB-first macro and bits fed LSB-first → lt=1 in both builds.
- start pulses during SHIFT, and bit_valid toggled in IDLE → no effect on the counter or result. Back-to-back start in DONE → second result arrives 8 cycles later.
- Assert rst_n low after 4 accepted bits → outputs 000 and busy=0 immediately. A fresh run of A=0xFF, B=0x00 → gt=1.
- WIDTH=1: A=0, B=1 → lt=1 one cycle after the start edge.
